mem_read_arbiter: RTL
=====================

// Module: mem_read_arbiter
// PURPOSE
//  Shares one AXI-style read port (address + data channel) between NUM_REQ cache refill masters
//  (req 0 = i_cache, req 1 = d_cache). Round-robin grants whole bursts, one outstanding at a time.
//  Drives mem ARID with the owner index and routes R beats back to the owner only.
//  Sits between the caches' axi_read_address/axi_read_data masters and the memory model.
// PARAMETERS
//  NUM_REQ     2   number of requesters, 2..8
//  ADDR_WIDTH  26  byte address width (`ADDR_WIDTH)
//  DATA_WIDTH  32  beat width (`DATA_WIDTH)
//  ID_WIDTH    4   ARID/RID width, must satisfy 2**ID_WIDTH >= NUM_REQ
// PORTS
//  clk          in   1                     clock
//  rst          in   1                     reset, synchronous, active-high
//  req_araddr   in   NUM_REQ*ADDR_WIDTH    per-requester burst address, slice i = req i
//  req_arlen    in   NUM_REQ*8             per-requester beat count (number of beats, not len-1)
//  req_arvalid  in   NUM_REQ               request valid, held until req_arready
//  req_arready  out  NUM_REQ               address accepted (one-cycle pulse)
//  req_rdata    out  DATA_WIDTH            beat data, broadcast to all requesters
//  req_rvalid   out  NUM_REQ               beat valid, owner bit only
//  req_rready   in   NUM_REQ               requester beat ready
//  mem_araddr   out  ADDR_WIDTH            latched owner address
//  mem_arlen    out  8                     latched owner beat count
//  mem_arid     out  ID_WIDTH              owner index, zero-extended
//  mem_arvalid  out  1                     address valid to memory
//  mem_arready  in   1                     memory accepts address
//  mem_rdata    in   DATA_WIDTH            memory beat data
//  mem_rvalid   in   1                     memory beat valid
//  mem_rready   out  1                     = req_rready[owner] in S_DATA, else 0
//  busy         out  1                     state != S_IDLE
// BEHAVIOUR
//  States: S_IDLE, S_ADDR, S_DATA. Regs: owner, rr_ptr, addr/len latch, beat_cnt (8b).
//  Reset (rst=1 at clk edge): state=S_IDLE, rr_ptr=0, owner=0, beat_cnt=0. After the edge all outputs are 0:
//   mem_arvalid, mem_rready, req_arready, req_rvalid, busy. mem_araddr/arlen/arid=0.
//   rst mid-burst abandons the burst with no further routing; memory is reset by the same rst.
//  Arbitration: first requester with arvalid set, searching from rr_ptr upward modulo NUM_REQ.
//   Taken in S_IDLE, or in S_DATA on the last-beat cycle, so back-to-back bursts have no idle cycle.
//   Grant latches owner, req_araddr[owner], req_arlen[owner] (len 0 latched as 1) -> S_ADDR next cycle.
//  S_ADDR: mem_arvalid=1 from the latches.
//   On mem_arready=1: req_arready[owner]=1 that cycle, beat_cnt=0, -> S_DATA.
//   ARVALID-to-ARVALID latency is 1 cycle (request seen at N, mem_arvalid at N+1).
//  S_DATA: req_rdata=mem_rdata.
//   req_rvalid[owner]=mem_rvalid; mem_rready=req_rready[owner].
//   Beat transfers when mem_rvalid & mem_rready; then beat_cnt++.
//   Last beat is beat_cnt==len-1 with a transfer.
//   On the last beat: rr_ptr=(owner+1)%NUM_REQ, then re-arbitrate with the new pointer.
//   Any request -> S_ADDR, else -> S_IDLE.
//  mem_rvalid outside S_DATA is ignored (mem_rready=0). mem RID is not checked; one burst in flight.
//  A requester deasserting arvalid before arready is illegal. Behaviour is undefined and a bench assertion flags it.
//  Non-owner req_rvalid bits are always 0. req_arready is never high for more than one bit or outside S_ADDR.
// TESTING
//  1 req0 arvalid addr=0x0000100 len=8, arready same cycle as arvalid, 8 rvalid beats -> mem_arid=0;
//    8 req_rvalid[0] pulses, data in order; busy drops after beat 8; rr_ptr=1.
//  2 req0,req1 arvalid same cycle from reset -> req0 burst first; req1 AR issued on cycle after
//    req0 last beat (no S_IDLE); mem_arid=1; then req0 re-request wins next round.
//  3 mem_arready held low 3 cycles -> mem_arvalid/addr stable 3 cycles; req_arready[owner] pulses once on 4th.
//  4 req1 rready low 2 cycles mid-burst with mem_rvalid high -> mem_rready low; no beat lost; beat_cnt frozen.
//  5 rst asserted at beat 4 of 8 -> next cycle all outputs 0, busy=0; new req1 burst completes normally.
//  6 len=0 request -> treated as one beat, single req_rvalid pulse, returns to S_IDLE.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
// Shares one AXI-style read port (address + data channel) between NUM_REQ
// cache refill masters. Requesters are served round-robin, one whole burst at
// a time with a single burst in flight. The owner index is driven on ARID and
// R beats are routed back to the owner only; rdata is broadcast.

module mem_read_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
   input  logic [NUM_REQ*8-1:0]          req_arlen,
   input  logic [NUM_REQ-1:0]            req_arvalid,
   output logic [NUM_REQ-1:0]            req_arready,
   output logic [DATA_WIDTH-1:0]         req_rdata,
   output logic [NUM_REQ-1:0]            req_rvalid,
   input  logic [NUM_REQ-1:0]            req_rready,
   output logic [ADDR_WIDTH-1:0]         mem_araddr,
   output logic [7:0]                    mem_arlen,
   output logic [ID_WIDTH-1:0]           mem_arid,
   output logic                          mem_arvalid,
   input  logic                          mem_arready,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   input  logic                          mem_rvalid,
   output logic                          mem_rready,
   output logic                          busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   // Round-robin search: first set bit of req starting at ptr, wrapping.
   // Returns {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   ptr);
      logic             found;
      logic [IDX_W-1:0] idx;
      int               cand;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end else begin
            cand = cand;
         end
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = IDX_W'(cand);
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   state_t                  state_r;
   logic [IDX_W-1:0]        owner_r;
   logic [IDX_W-1:0]        rr_ptr_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [7:0]              len_r;
   logic [7:0]              beat_cnt_r;
   logic                    busy_r;
   logic                    mem_arvalid_r;

   logic                    in_data_s;
   logic                    owner_rready_s;
   logic                    beat_xfer_s;
   logic                    last_beat_s;
   logic [IDX_W-1:0]        next_ptr_s;
   logic [IDX_W-1:0]        arb_ptr_s;
   logic [IDX_W:0]          pick_s;
   logic                    grant_any_s;
   logic [IDX_W-1:0]        grant_idx_s;
   logic [ADDR_WIDTH-1:0]   grant_addr_s;
   logic [7:0]              grant_len_raw_s;
   logic [7:0]              grant_len_s;
   logic [NUM_REQ-1:0]      owner_onehot_s;

   // Burst progress and arbitration decode for the current cycle.
   always_comb begin
      in_data_s      = (state_r == S_DATA);
      owner_rready_s = req_rready[owner_r];
      beat_xfer_s    = in_data_s & mem_rvalid & owner_rready_s;
      last_beat_s    = beat_xfer_s & (beat_cnt_r == (len_r - 8'd1));

      if (owner_r == IDX_W'(NUM_REQ - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = owner_r + IDX_W'(1);
      end

      // On the last beat the pointer has already moved past the owner.
      if (state_r == S_DATA) begin
         arb_ptr_s = next_ptr_s;
      end else begin
         arb_ptr_s = rr_ptr_r;
      end

      pick_s          = rr_pick(req_arvalid, arb_ptr_s);
      grant_any_s     = pick_s[IDX_W];
      grant_idx_s     = pick_s[IDX_W-1:0];
      grant_addr_s    = req_araddr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
      grant_len_raw_s = req_arlen[grant_idx_s*8 +: 8];

      // A zero beat count still moves one beat.
      if (grant_len_raw_s == 8'd0) begin
         grant_len_s = 8'd1;
      end else begin
         grant_len_s = grant_len_raw_s;
      end

      owner_onehot_s          = '0;
      owner_onehot_s[owner_r] = 1'b1;
   end

   // Burst FSM: owner/pointer bookkeeping, address latch and registered status.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= S_IDLE;
         owner_r       <= '0;
         rr_ptr_r      <= '0;
         addr_r        <= '0;
         len_r         <= 8'd0;
         beat_cnt_r    <= 8'd0;
         busy_r        <= 1'b0;
         mem_arvalid_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (grant_any_s) begin
                  owner_r       <= grant_idx_s;
                  addr_r        <= grant_addr_s;
                  len_r         <= grant_len_s;
                  state_r       <= S_ADDR;
                  busy_r        <= 1'b1;
                  mem_arvalid_r <= 1'b1;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_ADDR: begin
               if (mem_arready) begin
                  beat_cnt_r    <= 8'd0;
                  state_r       <= S_DATA;
                  mem_arvalid_r <= 1'b0;
               end else begin
                  state_r <= S_ADDR;
               end
            end
            S_DATA: begin
               if (last_beat_s) begin
                  rr_ptr_r <= next_ptr_s;
                  // Chain straight into the next burst without an idle cycle.
                  if (grant_any_s) begin
                     owner_r       <= grant_idx_s;
                     addr_r        <= grant_addr_s;
                     len_r         <= grant_len_s;
                     state_r       <= S_ADDR;
                     mem_arvalid_r <= 1'b1;
                  end else begin
                     state_r <= S_IDLE;
                     busy_r  <= 1'b0;
                  end
               end else if (beat_xfer_s) begin
                  beat_cnt_r <= beat_cnt_r + 8'd1;
               end else begin
                  beat_cnt_r <= beat_cnt_r;
               end
            end
            default: begin
               state_r       <= S_IDLE;
               busy_r        <= 1'b0;
               mem_arvalid_r <= 1'b0;
            end
         endcase
      end
   end

   // Channel routing: handshakes go to the owner only, everything else is held at 0.
   always_comb begin
      req_arready = '0;
      req_rvalid  = '0;
      req_rdata   = '0;
      mem_rready  = 1'b0;
      if ((state_r == S_ADDR) && mem_arready) begin
         req_arready = owner_onehot_s;
      end else begin
         req_arready = '0;
      end
      if (in_data_s) begin
         req_rdata  = mem_rdata;
         mem_rready = owner_rready_s;
         if (mem_rvalid) begin
            req_rvalid = owner_onehot_s;
         end else begin
            req_rvalid = '0;
         end
      end else begin
         req_rdata  = '0;
         mem_rready = 1'b0;
         req_rvalid = '0;
      end
   end

   assign mem_araddr  = addr_r;
   assign mem_arlen   = len_r;
   assign mem_arid    = ID_WIDTH'(owner_r);
   assign mem_arvalid = mem_arvalid_r;
   assign busy        = busy_r;

endmodule
